// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: runs the fetch PC against a one-cycle instruction memory
// and buffers {pc+4, ir} pairs for decode behind a valid/ready handshake.
module inst_prefetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          redirect,
    input  logic [31:0]   redirect_addr,
    output logic          imem_req,
    output logic [31:0]   imem_addr,
    input  logic [31:0]   imem_rdata,
    output logic          dec_valid,
    input  logic          dec_ready,
    output logic [31:0]   dec_pc,
    output logic [31:0]   dec_ir,
    output logic [AW:0]   count
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } entry_t;

    entry_t          fifo [DEPTH];
    logic [31:0]     fetch_pc;
    logic [31:0]     resp_pc;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            inflight;

    logic [AW+1:0]   occupancy;
    logic            issue;
    logic            push;
    logic            pop;
    entry_t          head;

    // Reserve a slot for the in-flight fetch so a returning response always fits.
    assign occupancy = (AW+2)'(count) + (AW+2)'(inflight);
    assign issue     = rst & ~redirect & (occupancy < (AW+2)'(DEPTH));
    assign push      = inflight & ~redirect;
    assign pop       = dec_valid & dec_ready;

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;
    assign dec_valid = (count != '0) & ~redirect;

    assign head      = fifo[rd_ptr];
    assign dec_pc    = (count != '0) ? head.pc : 32'h0;
    assign dec_ir    = (count != '0) ? head.ir : 32'h0;

    // Fetch PC and in-flight tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= 32'h0;
            resp_pc  <= 32'h0;
            inflight <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= {redirect_addr[31:2], 2'b00};
            inflight <= 1'b0;
        end else if (issue) begin
            fetch_pc <= fetch_pc + 32'd4;
            resp_pc  <= fetch_pc + 32'd4;
            inflight <= 1'b1;
        end else begin
            inflight <= 1'b0;
        end
    end

    // FIFO pointers and occupancy; redirect discards everything buffered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) fifo[i] <= '0;
        end else if (push) begin
            fifo[wr_ptr] <= '{pc: resp_pc, ir: imem_rdata};
        end
    end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Randomized bench for inst_prefetch_queue checked against a queue-based fetch model.
module tb_inst_prefetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;
    localparam logic [31:0] K     = 32'hA5A5_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          redirect = 1'b0;
    logic [31:0]   redirect_addr = 32'h0;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_rdata = 32'h0;
    logic          dec_valid;
    logic          dec_ready = 1'b0;
    logic [31:0]   dec_pc;
    logic [31:0]   dec_ir;
    logic [AW:0]   count;

    int total = 0;
    int bad   = 0;

    // Reference model: architectural fetch PC, buffered pairs, one outstanding fetch.
    logic [31:0] m_pc;
    logic        m_infl;
    logic [31:0] m_infl_addr;
    logic [63:0] q [$];

    inst_prefetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_addr(redirect_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc),
        .dec_ir(dec_ir), .count(count)
    );

    always #5 clk = ~clk;

    // One-cycle-latency instruction memory.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr ^ K;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0;
        m_infl = 1'b0;
        m_infl_addr = 32'h0;
        q.delete();
    endtask

    // Drive one cycle from a negedge, check outputs, advance the model, end at next negedge.
    task automatic step(input logic redir, input logic [31:0] raddr, input logic rdy);
        logic        e_req, e_valid;
        logic [31:0] e_pc, e_ir;
        redirect = redir;
        redirect_addr = raddr;
        dec_ready = rdy;
        #1;
        e_req   = !redir && (q.size() + (m_infl ? 1 : 0) < DEPTH);
        e_valid = (q.size() != 0) && !redir;
        e_pc    = (q.size() != 0) ? q[0][63:32] : 32'h0;
        e_ir    = (q.size() != 0) ? q[0][31:0]  : 32'h0;
        chk("imem_req",  32'(imem_req),  32'(e_req));
        chk("imem_addr", imem_addr,      m_pc);
        chk("dec_valid", 32'(dec_valid), 32'(e_valid));
        chk("dec_pc",    dec_pc,         e_pc);
        chk("dec_ir",    dec_ir,         e_ir);
        chk("count",     32'(count),     32'(q.size()));
        if (redir) begin
            q.delete();
            m_infl = 1'b0;
            m_pc = raddr & 32'hFFFF_FFFC;
        end else begin
            if (e_valid && rdy) void'(q.pop_front());
            if (m_infl) q.push_back({m_infl_addr + 32'd4, m_infl_addr ^ K});
            m_infl = e_req;
            m_infl_addr = m_pc;
            if (e_req) m_pc = m_pc + 32'd4;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        redirect = 1'b0;
        dec_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_imem_req",  32'(imem_req),  32'h0);
        chk("rst_imem_addr", imem_addr,      32'h0);
        chk("rst_dec_valid", 32'(dec_valid), 32'h0);
        chk("rst_dec_pc",    dec_pc,         32'h0);
        chk("rst_dec_ir",    dec_ir,         32'h0);
        chk("rst_count",     32'(count),     32'h0);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(negedge clk);

        // Streaming with decode always ready.
        do_reset();
        repeat (10) step(1'b0, 32'h0, 1'b1);

        // Backpressure from reset, then drain.
        do_reset();
        repeat (8) step(1'b0, 32'h0, 1'b0);
        chk("sat_count", 32'(count), 32'd4);
        repeat (10) step(1'b0, 32'h0, 1'b1);

        // Redirect with three buffered and one in flight.
        do_reset();
        repeat (4) step(1'b0, 32'h0, 1'b0);
        chk("pre_redir_count", 32'(count), 32'd3);
        step(1'b1, 32'h0000_0100, 1'b0);
        repeat (6) step(1'b0, 32'h0, 1'b1);

        // Misaligned target and address wrap.
        step(1'b1, 32'h0000_0203, 1'b1);
        repeat (5) step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'hFFFF_FFFC, 1'b1);
        repeat (5) step(1'b0, 32'h0, 1'b1);

        // Asynchronous reset between edges with two entries buffered.
        do_reset();
        repeat (3) step(1'b0, 32'h0, 1'b0);
        chk("pre_async_count", 32'(count), 32'd2);
        #2 rst = 1'b0;
        #1;
        chk("async_dec_valid", 32'(dec_valid), 32'h0);
        chk("async_count",     32'(count),     32'h0);
        chk("async_imem_req",  32'(imem_req),  32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (6) step(1'b0, 32'h0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0)
                step(1'b1, $urandom, ($urandom_range(0, 3) != 0));
            else
                step(1'b0, 32'h0, ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
